// File: rtl/serial_cmd_sequencer_if.sv
// Control/serial bundle for serial_cmd_sequencer.
// slave: the sequencer's view; master: the control layer's view.
interface serial_cmd_sequencer_if #(
  parameter int NUM_FRAMES = 3
);
  localparam int IDX_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  logic                  start_in;
  logic                  abort_in;
  logic [NUM_FRAMES-1:0] frame_mask_in;
  logic                  ser_clk_out;
  logic                  ser_data_out;
  logic                  busy_out;
  logic                  done_out;
  logic [IDX_W-1:0]      frame_idx_out;

  modport slave (
    input  start_in, abort_in, frame_mask_in,
    output ser_clk_out, ser_data_out, busy_out, done_out, frame_idx_out
  );

  modport master (
    output start_in, abort_in, frame_mask_in,
    input  ser_clk_out, ser_data_out, busy_out, done_out, frame_idx_out
  );
endinterface

// File: rtl/serial_cmd_sequencer.sv
// Bit-serial command sequencer: on a start button press, shifts the enabled
// stored frames out MSB first, with an idle gap between consecutive frames.
// Serial clock and data come from a bit-period divider in the clk_in domain.
module serial_cmd_sequencer #(
  parameter int CLK_DIV    = 160,
  parameter int FRAME_LEN  = 58,
  parameter int NUM_FRAMES = 3,
  parameter int GAP_BITS   = 10000,
  parameter logic IDLE_LEVEL = 1'b1,
  parameter logic [NUM_FRAMES*FRAME_LEN-1:0] FRAME_DATA = '1
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  serial_cmd_sequencer_if.slave  bus
);
  localparam int DIV_W = (CLK_DIV > 1)   ? $clog2(CLK_DIV)    : 1;
  localparam int BIT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN)  : 1;
  localparam int GAP_W = $clog2(GAP_BITS + 1);
  localparam int IDX_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  localparam logic [NUM_FRAMES-1:0][FRAME_LEN-1:0] FRAMES = FRAME_DATA;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]      frame_idx_q, frame_idx_d;
  logic [NUM_FRAMES-1:0] mask_q, mask_d;
  logic                  sync1_q, sync2_q, start_dly_q;

  logic                  start_fall;
  logic                  first_found, next_found;
  logic [IDX_W-1:0]      first_idx, next_idx;
  logic                  bit_end;

  // Two-flop synchroniser plus a delay stage for falling-edge detection.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      start_dly_q <= 1'b1;
    end else begin
      sync1_q     <= bus.start_in;
      sync2_q     <= sync1_q;
      start_dly_q <= sync2_q;
    end
  end

  assign start_fall = start_dly_q & ~sync2_q;

  // Lowest enabled frame in the incoming mask, and the next enabled frame
  // above the current one in the latched mask.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int unsigned i = 0; i < NUM_FRAMES; i++) begin
      if (bus.frame_mask_in[i] && !first_found) begin
        first_found = 1'b1;
        first_idx   = IDX_W'(i);
      end
      if (mask_q[i] && (IDX_W'(i) > frame_idx_q) && !next_found) begin
        next_found = 1'b1;
        next_idx   = IDX_W'(i);
      end
    end
  end

  assign bit_end = (div_cnt_q == DIV_W'(CLK_DIV - 1));

  // Next-state logic for the sequencer FSM and its counters.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    frame_idx_d = frame_idx_q;
    mask_d      = mask_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_fall) begin
          mask_d    = bus.frame_mask_in;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          if (first_found) begin
            state_d     = S_SEND;
            frame_idx_d = first_idx;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SEND: begin
        if (bus.abort_in) begin
          state_d   = S_IDLE;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          mask_d    = '0;
        end else if (bit_end) begin
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_W'(FRAME_LEN - 1)) begin
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = next_found ? S_GAP : S_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (bus.abort_in) begin
          state_d   = S_IDLE;
          div_cnt_d = '0;
          gap_cnt_d = '0;
          mask_d    = '0;
        end else if (bit_end) begin
          div_cnt_d = '0;
          if (gap_cnt_q == GAP_W'(GAP_BITS - 1)) begin
            gap_cnt_d   = '0;
            state_d     = S_SEND;
            frame_idx_d = next_idx;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        mask_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      frame_idx_q <= '0;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_idx_q <= frame_idx_d;
      mask_q      <= mask_d;
    end
  end

  // Outputs decode straight from registered state, so async reset
  // forces them to idle values without waiting for a clock edge.
  assign bus.ser_clk_out   = (state_q == S_SEND) && (div_cnt_q >= DIV_W'(CLK_DIV / 2));
  assign bus.ser_data_out  = (state_q == S_SEND)
                             ? FRAMES[frame_idx_q][BIT_W'(FRAME_LEN - 1) - bit_cnt_q]
                             : IDLE_LEVEL;
  assign bus.busy_out      = (state_q == S_SEND) || (state_q == S_GAP);
  assign bus.done_out      = (state_q == S_DONE);
  assign bus.frame_idx_out = frame_idx_q;
endmodule

// File: tb/tb_serial_cmd_sequencer.sv
// Self-checking bench for serial_cmd_sequencer with a per-cycle expected
// waveform built from frame list, bit timing and gap rules.
module tb_serial_cmd_sequencer;
  localparam int CLK_DIV = 4;
  localparam int FLEN    = 8;
  localparam int NF      = 3;
  localparam int GAPB    = 2;

  typedef struct {
    bit sclk;
    bit sdata;
    bit busy;
    bit done;
    int idx;
    bit chk_idx;
  } exp_t;

  logic clk_in;
  logic reset_in;
  int   checks;
  int   errors;
  int   obs_busy, obs_done, obs_rises;
  exp_t exp_q[$];
  bit [7:0] frm [NF];

  serial_cmd_sequencer_if #(.NUM_FRAMES(NF)) bus ();

  serial_cmd_sequencer #(
    .CLK_DIV   (CLK_DIV),
    .FRAME_LEN (FLEN),
    .NUM_FRAMES(NF),
    .GAP_BITS  (GAPB),
    .IDLE_LEVEL(1'b1),
    .FRAME_DATA({8'hC3, 8'h0F, 8'hA5})
  ) dut (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .bus     (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic void add(bit sclk, bit sdata, bit busy, bit done, int idx, bit chk);
    exp_t e;
    e.sclk = sclk; e.sdata = sdata; e.busy = busy; e.done = done;
    e.idx = idx; e.chk_idx = chk;
    exp_q.push_back(e);
  endfunction

  // Expected waveform, one entry per clk cycle, starting with the cycle in
  // which the first bit (or the done pulse for an empty mask) appears.
  function automatic void build_trace(bit [2:0] mask, int abort_at);
    int en[$];
    int last;
    exp_q.delete();
    last = 0;
    for (int f = 0; f < NF; f++) if (mask[f]) en.push_back(f);
    foreach (en[k]) begin
      if (k > 0)
        for (int g = 0; g < GAPB * CLK_DIV; g++) add(0, 1, 1, 0, en[k-1], 1);
      for (int b = 0; b < FLEN; b++)
        for (int c = 0; c < CLK_DIV; c++)
          add(c >= CLK_DIV / 2, frm[en[k]][FLEN-1-b], 1, 0, en[k], 1);
      last = en[k];
    end
    add(0, 1, 0, 1, last, en.size() > 0);
    add(0, 1, 0, 0, last, en.size() > 0);
    add(0, 1, 0, 0, last, en.size() > 0);
    if (abort_at >= 0 && abort_at < exp_q.size() && exp_q[abort_at].busy) begin
      while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
      add(0, 1, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0);
    end
  endfunction

  // Press start (at a negedge), follow the expected trace cycle by cycle.
  task automatic run_seq(input bit [2:0] mask, input int abort_at, input int glitch_at,
                         input bit hold, input string name);
    bit prev_sclk;
    obs_busy = 0; obs_done = 0; obs_rises = 0; prev_sclk = 0;
    build_trace(mask, abort_at);
    bus.frame_mask_in = mask;
    bus.start_in = 1'b0;
    for (int p = 0; p < 2; p++) begin
      @(negedge clk_in);
      checks++;
      if ({bus.ser_clk_out, bus.busy_out, bus.done_out} !== 3'b000) begin
        errors++;
        $display("FAIL %s presync%0d clk,busy,done got %b exp 000", name, p,
                 {bus.ser_clk_out, bus.busy_out, bus.done_out});
      end
    end
    for (int n = 0; n < exp_q.size(); n++) begin
      exp_t e;
      e = exp_q[n];
      @(negedge clk_in);
      if (bus.ser_clk_out === 1'b1 && prev_sclk == 1'b0) obs_rises++;
      prev_sclk = bus.ser_clk_out;
      if (bus.busy_out === 1'b1) obs_busy++;
      if (bus.done_out === 1'b1) obs_done++;
      checks++;
      if ({bus.ser_clk_out, bus.ser_data_out, bus.busy_out, bus.done_out} !==
          {e.sclk, e.sdata, e.busy, e.done}) begin
        errors++;
        $display("FAIL %s cyc %0d clk,data,busy,done got %b exp %b", name, n,
                 {bus.ser_clk_out, bus.ser_data_out, bus.busy_out, bus.done_out},
                 {e.sclk, e.sdata, e.busy, e.done});
      end
      if (e.chk_idx) begin
        checks++;
        if (bus.frame_idx_out !== 2'(e.idx)) begin
          errors++;
          $display("FAIL %s cyc %0d frame_idx got %0d exp %0d", name, n,
                   bus.frame_idx_out, e.idx);
        end
      end
      bus.abort_in = (n == abort_at);
      if (n == 5) bus.frame_mask_in = 3'($urandom);
      if (n == glitch_at) bus.start_in = 1'b1;
      if (glitch_at >= 0 && n == glitch_at + 4) bus.start_in = 1'b0;
    end
    bus.abort_in = 1'b0;
    if (!hold) begin
      bus.start_in = 1'b1;
      repeat (3) @(negedge clk_in);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({bus.ser_clk_out, bus.ser_data_out, bus.busy_out, bus.done_out, bus.frame_idx_out}
        !== 6'b010000) begin
      errors++;
      $display("FAIL %s clk,data,busy,done,idx got %b exp 010000", name,
               {bus.ser_clk_out, bus.ser_data_out, bus.busy_out, bus.done_out, bus.frame_idx_out});
    end
  endtask

  task automatic test_reset();
    reset_in = 1'b0;
    bus.start_in = 1'b1;
    bus.abort_in = 1'b0;
    bus.frame_mask_in = '0;
    #2;
    check_reset_vals("reset_async");
    repeat (2) @(negedge clk_in);
    check_reset_vals("reset_held");
    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check_reset_vals("reset_release_idle");
  endtask

  task automatic test_full();
    run_seq(3'b111, -1, -1, 0, "full111");
    checks++;
    if (obs_busy !== 112) begin errors++; $display("FAIL full111_busy got %0d exp 112", obs_busy); end
    checks++;
    if (obs_done !== 1) begin errors++; $display("FAIL full111_done got %0d exp 1", obs_done); end
    checks++;
    if (obs_rises !== 24) begin errors++; $display("FAIL full111_rises got %0d exp 24", obs_rises); end
  endtask

  task automatic test_skip();
    run_seq(3'b101, -1, -1, 0, "mask101");
    checks++;
    if (obs_busy !== 72) begin errors++; $display("FAIL mask101_busy got %0d exp 72", obs_busy); end
    checks++;
    if (obs_rises !== 16) begin errors++; $display("FAIL mask101_rises got %0d exp 16", obs_rises); end
  endtask

  task automatic test_empty();
    run_seq(3'b000, -1, -1, 0, "mask000");
    checks++;
    if (obs_busy !== 0 || obs_rises !== 0) begin
      errors++;
      $display("FAIL mask000_activity busy %0d rises %0d exp 0 0", obs_busy, obs_rises);
    end
    checks++;
    if (obs_done !== 1) begin errors++; $display("FAIL mask000_done got %0d exp 1", obs_done); end
  endtask

  task automatic test_back_to_back();
    run_seq(3'b111, -1, 44, 1, "b2b_first");
    checks++;
    if (obs_done !== 1) begin errors++; $display("FAIL b2b_done got %0d exp 1", obs_done); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_in);
      checks++;
      if (bus.busy_out !== 1'b0 || bus.done_out !== 1'b0) begin
        errors++;
        $display("FAIL b2b_held cyc %0d busy,done got %b%b exp 00", c, bus.busy_out, bus.done_out);
      end
    end
    bus.start_in = 1'b1;
    repeat (3) @(negedge clk_in);
    run_seq(3'b111, -1, -1, 0, "b2b_second");
    checks++;
    if (obs_busy !== 112) begin errors++; $display("FAIL b2b_second_busy got %0d exp 112", obs_busy); end
  endtask

  task automatic test_abort();
    // bit 3 of frame 1 begins 32 + 8 + 3*4 cycles into the run
    run_seq(3'b111, 52, -1, 0, "abort");
    checks++;
    if (obs_done !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", obs_done); end
    run_seq(3'b111, -1, -1, 0, "after_abort");
    checks++;
    if (obs_done !== 1) begin errors++; $display("FAIL after_abort_done got %0d exp 1", obs_done); end
  endtask

  task automatic test_reset_in_gap();
    bus.frame_mask_in = 3'b111;
    bus.start_in = 1'b0;
    // second gap (between frames 1 and 2) spans run cycles 72..79
    repeat (2 + 76) @(negedge clk_in);
    checks++;
    if (bus.busy_out !== 1'b1 || bus.frame_idx_out !== 2'd1) begin
      errors++;
      $display("FAIL gap_precheck busy,idx got %b,%0d exp 1,1", bus.busy_out, bus.frame_idx_out);
    end
    #1 reset_in = 1'b0;
    #1 check_reset_vals("reset_in_gap");
    bus.start_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      check_reset_vals("reset_gap_held");
    end
    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check_reset_vals("reset_gap_release");
    run_seq(3'b111, -1, -1, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      bit [2:0] m;
      int ab;
      m  = 3'($urandom_range(0, 7));
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 120)) : -1;
      run_seq(m, ab, -1, 0, "random");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    frm[0] = 8'hA5;
    frm[1] = 8'h0F;
    frm[2] = 8'hC3;
    test_reset();
    test_full();
    test_skip();
    test_empty();
    test_back_to_back();
    test_abort();
    test_reset_in_gap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
